// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared definitions for the instruction fetch stage: FSM state encodings,
//   the NOP word driven while bubbling or halted, and the PC increment helper.
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IFS_RUN  = 2'd0,   // fetching normally
        IFS_WAIT = 2'd1,   // branch outstanding, bubbling until EX resolves it
        IFS_HALT = 2'd2    // frozen after a halt instruction
    } ifs_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Sequential PC step; the 32-bit result wraps from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_perf_counters.sv
// ---------------------------------------------------------------------------
// if_perf_counters
//   Two free-running performance counters for the fetch stage.
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset, clears both counters
//     cyc_en_i     count this cycle in cyc_cnt_o
//     bubble_en_i  count this cycle in bubble_cnt_o
//     cyc_cnt_o    cycle count, wraps at 2^CNT_W
//     bubble_cnt_o bubble count, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module if_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cyc_en_i,
    input  logic             bubble_en_i,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        cyc_d    = cyc_en_i    ? cyc_q + CNT_W'(1)    : cyc_q;
        bubble_d = bubble_en_i ? bubble_q + CNT_W'(1) : bubble_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            bubble_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            bubble_q <= bubble_d;
        end
    end

    assign cyc_cnt_o    = cyc_q;
    assign bubble_cnt_o = bubble_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Fetch stage feeding the IF/ID register. Owns the PC, drives the
//   instruction-memory address and presents pc/npc/instr downstream.
//   Handles load-use stall, jump redirect, branch bubbling until EX resolves,
//   and the halt freeze.
//   Ports:
//     clk, reset            clock; asynchronous active-low reset
//     stall                 hold PC (load-use), defers all RUN events
//     pc_bobl               current instr is a conditional branch
//     jpc_en, jpc           jump redirect request and target
//     br_resolve/taken/target  branch resolution from EX
//     halt                  current instr is halt
//     imem_addr/imem_rdata  zero-latency instruction memory port
//     pc, npc, instr        values presented to IF/ID
//     jpc_head              pc[31:28] for jump target formation
//     halted                halt freeze in effect
//     err_spurious          sticky: branch resolution seen outside WAIT
//     cyc_cnt, bubble_cnt   performance counters
// ---------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_bobl,
    input  logic             jpc_en,
    input  logic [31:0]      jpc,
    input  logic             br_resolve,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             halt,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      npc,
    output logic [31:0]      instr,
    output logic [3:0]       jpc_head,
    output logic             halted,
    output logic             err_spurious,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ifs_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;
    logic        cyc_en;
    logic        bubble_en;

    assign pc_plus4 = pc_inc(pc_q);

    // State register (PC and sticky error share the same reset domain).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IFS_RUN;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-PC.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        // A resolution is only expected while a branch is outstanding.
        err_d   = err_q | (br_resolve & (state_q != IFS_WAIT));

        unique case (state_q)
            IFS_HALT: ;
            IFS_WAIT: begin
                // Resolution wins over stall; all other events are ignored.
                if (br_resolve) begin
                    state_d = IFS_RUN;
                    if (br_taken) pc_d = br_target;
                end
            end
            IFS_RUN: begin
                if (stall) begin
                    // Hold everything; pending jump/branch/halt re-present later.
                end else if (halt) begin
                    state_d = IFS_HALT;
                end else if (jpc_en) begin
                    pc_d = jpc;
                end else if (pc_bobl) begin
                    // Branch word goes out this cycle; fall-through is parked in pc.
                    pc_d    = pc_plus4;
                    state_d = IFS_WAIT;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            default: state_d = IFS_RUN;
        endcase
    end

    // Outputs.
    always_comb begin
        instr     = (state_q == IFS_RUN) ? imem_rdata : NOP_INSTR;
        halted    = (state_q == IFS_HALT);
        cyc_en    = (state_q != IFS_HALT);
        bubble_en = (state_q == IFS_WAIT) && !br_resolve;
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign npc          = pc_plus4;
    assign jpc_head     = pc_q[31:28];
    assign err_spurious = err_q;

    if_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (reset),
        .cyc_en_i     (cyc_en),
        .bubble_en_i  (bubble_en),
        .cyc_cnt_o    (cyc_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. Stimulus drives inputs just after each
//   rising edge and queues the outputs expected for that cycle; a monitor
//   pops the queue on each falling edge and compares.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam int          CNT_W = 32;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] KEY   = 32'hC0DE_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             stall, pc_bobl, jpc_en, br_resolve, br_taken, halt;
    logic [31:0]      jpc, br_target;
    logic [31:0]      imem_addr, imem_rdata, pc, npc, instr;
    logic [3:0]       jpc_head;
    logic             halted, err_spurious;
    logic [CNT_W-1:0] cyc_cnt, bubble_cnt;

    typedef struct {
        logic [31:0]      pc;
        logic             run;
        logic             halted;
        logic             err;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] bub;
    } exp_t;

    exp_t             sb[$];
    logic             e_err = 1'b0;
    logic [CNT_W-1:0] e_cyc = '0;
    logic [CNT_W-1:0] e_bub = '0;
    int               checks = 0;
    int               errors = 0;
    bit               stim_done = 1'b0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .CNT_W     (CNT_W),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_bobl      (pc_bobl),
        .jpc_en       (jpc_en),
        .jpc          (jpc),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .halt         (halt),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .npc          (npc),
        .instr        (instr),
        .jpc_head     (jpc_head),
        .halted       (halted),
        .err_spurious (err_spurious),
        .cyc_cnt      (cyc_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    // Every address returns a distinct word.
    assign imem_rdata = KEY ^ imem_addr;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge and return all inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        stall = 1'b0; pc_bobl = 1'b0; jpc_en = 1'b0; jpc = '0;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;
    endtask

    // Queue expected outputs for the current cycle. cyc_inc/bub_inc say
    // whether the edge just passed should have bumped each counter.
    task automatic exp_out(input logic [31:0] p, input logic run, input logic hlt,
                           input int cyc_inc = 1, input int bub_inc = 0);
        exp_t e;
        e_cyc = e_cyc + CNT_W'(cyc_inc);
        e_bub = e_bub + CNT_W'(bub_inc);
        e.pc = p; e.run = run; e.halted = hlt; e.err = e_err;
        e.cyc = e_cyc; e.bub = e_bub;
        sb.push_back(e);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    initial begin
        exp_t        e;
        logic [31:0] e_npc;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                e_npc = e.pc + 32'd4;
                check("pc",         pc,           e.pc);
                check("imem_addr",  imem_addr,    e.pc);
                check("npc",        npc,          e_npc);
                check("jpc_head",   jpc_head,     e.pc[31:28]);
                check("instr",      instr,        e.run ? (KEY ^ e.pc) : NOP);
                check("halted",     halted,       e.halted);
                check("err",        err_spurious, e.err);
                check("cyc_cnt",    cyc_cnt,      e.cyc);
                check("bubble_cnt", bubble_cnt,   e.bub);
            end
        end
    end

    initial begin
        stall = 1'b0; pc_bobl = 1'b0; jpc_en = 1'b0; jpc = '0;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;

        // Reset state, held across an edge, then released.
        tick; exp_out(32'h0, 1, 0, 0);
        tick; reset = 1'b1; exp_out(32'h0, 1, 0, 0);

        // Sequential fetch.
        tick; exp_out(32'h4, 1, 0);
        tick; exp_out(32'h8, 1, 0);
        tick; exp_out(32'hC, 1, 0);

        // Three stalled edges at 0x10.
        tick; stall = 1'b1; exp_out(32'h10, 1, 0);
        tick; stall = 1'b1; exp_out(32'h10, 1, 0);
        tick; stall = 1'b1; exp_out(32'h10, 1, 0);
        tick; exp_out(32'h10, 1, 0);
        tick; exp_out(32'h14, 1, 0);
        tick; exp_out(32'h18, 1, 0);
        tick; exp_out(32'h1C, 1, 0);

        // Taken branch at 0x20: two bubbles, resolve under stall.
        tick; pc_bobl = 1'b1; exp_out(32'h20, 1, 0);
        tick; jpc_en = 1'b1; jpc = 32'h0000_0700; halt = 1'b1; exp_out(32'h24, 0, 0);
        tick; exp_out(32'h24, 0, 0, 1, 1);
        tick; br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h80; stall = 1'b1;
        exp_out(32'h24, 0, 0, 1, 1);

        // Not-taken branch at 0x80 falls through to 0x84.
        tick; pc_bobl = 1'b1; exp_out(32'h80, 1, 0);
        tick; exp_out(32'h84, 0, 0);
        tick; exp_out(32'h84, 0, 0, 1, 1);
        tick; br_resolve = 1'b1; br_taken = 1'b0; br_target = 32'h200;
        exp_out(32'h84, 0, 0, 1, 1);

        // Jump to 0x30, then jump beats branch at 0x30.
        tick; jpc_en = 1'b1; jpc = 32'h30; exp_out(32'h84, 1, 0);
        tick; jpc_en = 1'b1; jpc = 32'h100; pc_bobl = 1'b1; exp_out(32'h30, 1, 0);
        tick; exp_out(32'h100, 1, 0);

        // Spurious resolve in RUN: no pc effect, sticky error.
        tick; br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h300; exp_out(32'h104, 1, 0);
        tick; e_err = 1'b1; jpc_en = 1'b1; jpc = 32'h40; exp_out(32'h108, 1, 0);

        // Halt at 0x40, first deferred by stall, then frozen.
        tick; halt = 1'b1; stall = 1'b1; exp_out(32'h40, 1, 0);
        tick; halt = 1'b1; exp_out(32'h40, 1, 0);
        tick; jpc_en = 1'b1; jpc = 32'h500; br_resolve = 1'b1; br_taken = 1'b1;
        br_target = 32'h600; exp_out(32'h40, 0, 1);
        tick; exp_out(32'h40, 0, 1, 0);
        tick; exp_out(32'h40, 0, 1, 0);

        // Reset out of HALT, enter WAIT, then async reset mid-cycle.
        tick; reset = 1'b0; e_err = 1'b0; e_cyc = '0; e_bub = '0; exp_out(32'h0, 1, 0, 0);
        tick; reset = 1'b1; exp_out(32'h0, 1, 0, 0);
        tick; pc_bobl = 1'b1; exp_out(32'h4, 1, 0);
        tick; exp_out(32'h8, 0, 0);
        tick; reset = 1'b0; e_cyc = '0; e_bub = '0; exp_out(32'h0, 1, 0, 0);
        tick; reset = 1'b1; exp_out(32'h0, 1, 0, 0);

        // PC wrap at the top of the address space.
        tick; jpc_en = 1'b1; jpc = 32'hFFFF_FFFC; exp_out(32'h4, 1, 0);
        tick; exp_out(32'hFFFF_FFFC, 1, 0);
        tick; exp_out(32'h0, 1, 0);
        tick; exp_out(32'h4, 1, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: bench did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
